ring_pos_to_remote_packer: RTL

- Collects per-particle position offset packets from the position ring.
- Packs NUM_SUB_PACKETS of them into one AXI-Stream beat for the inter-FPGA link.
- Successor of the fixed 4-slot remote position controller: parametrised slot count and widths, full valid/ready handshake on both sides, output FIFO tolerating link backpressure, partial-beat tkeep, per-beat latched tdest.
- Sits between the position ring exit and the remote AXIS TX arbiter.

---
 rtl/ring_pos_to_remote_packer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ring_pos_to_remote_packer.sv
// Packs position-ring offset packets into multi-slot AXI-Stream beats for the
// inter-FPGA link, with a small output FIFO to ride out link backpressure.

module ring_pos_slot #(
  parameter int SUB_PACKET_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic                        clr,
  input  logic [SUB_PACKET_WIDTH-1:0] din,
  output logic [SUB_PACKET_WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= din;
    else if (clr)  q <= '0;
  end
endmodule

module ring_pos_to_remote_packer #(
  parameter int NUM_SUB_PACKETS   = 4,
  parameter int SUB_PACKET_WIDTH  = 128,
  parameter int OFFSET_WIDTH      = 23,
  parameter int ELEMENT_WIDTH     = 2,
  parameter int PARTICLE_ID_WIDTH = 8,
  parameter int GCID_WIDTH        = 3,
  parameter int LIFETIME_WIDTH    = 5,
  parameter int NODE_ID_WIDTH     = 4,
  parameter int TDEST_WIDTH       = 8,
  parameter int FIFO_DEPTH        = 4,
  localparam int TDATA_W = NUM_SUB_PACKETS*SUB_PACKET_WIDTH,
  localparam int PKT_W   = 3*OFFSET_WIDTH+ELEMENT_WIDTH+PARTICLE_ID_WIDTH,
  localparam int FC_W    = $clog2(FIFO_DEPTH)+1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NODE_ID_WIDTH-1:0]  i_dest_id,
  input  logic                      i_flush,
  input  logic [PKT_W-1:0]          i_offset_pkt,
  input  logic [3*GCID_WIDTH-1:0]   i_gcid,
  input  logic [LIFETIME_WIDTH-1:0] i_lifetime,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_axis_tvalid,
  input  logic                      i_axis_tready,
  output logic [TDATA_W-1:0]        o_axis_tdata,
  output logic [TDATA_W/8-1:0]      o_axis_tkeep,
  output logic                      o_axis_tlast,
  output logic [TDEST_WIDTH-1:0]    o_axis_tdest,
  output logic [FC_W-1:0]           o_fifo_count,
  output logic                      o_debug_burst_running,
  output logic                      o_debug_last_pos_sent
);
  localparam int NS      = NUM_SUB_PACKETS;
  localparam int OW      = OFFSET_WIDTH;
  localparam int SLOT_B  = SUB_PACKET_WIDTH/8;
  localparam int CNT_W   = $clog2(NS)+1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LANE3_W = PARTICLE_ID_WIDTH+ELEMENT_WIDTH+3*GCID_WIDTH+LIFETIME_WIDTH+1;

  if (LANE3_W > 32) begin : g_lane3_overflow
    $error("lane3 metadata does not fit in 32 bits");
  end

  logic [CNT_W-1:0] count;
  logic             burst_running;
  logic [FC_W-1:0]  fifo_cnt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty, push, pop;
  logic             live_acc, trig_a, trig_b;

  logic [SUB_PACKET_WIDTH-1:0]                  slot_din;
  logic [NS-1:0][SUB_PACKET_WIDTH-1:0]          slot_q;
  logic [NS-1:0][SUB_PACKET_WIDTH-1:0]          beat_data;
  logic [NS-1:0][SLOT_B-1:0]                    beat_keep;

  logic [TDATA_W-1:0]     mem_data [FIFO_DEPTH];
  logic [TDATA_W/8-1:0]   mem_keep [FIFO_DEPTH];
  logic [TDEST_WIDTH-1:0] mem_dest [FIFO_DEPTH];

  assign fifo_full  = (fifo_cnt == FC_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign o_ready    = !fifo_full;
  assign live_acc   = i_valid && o_ready && (i_lifetime != '0);
  assign trig_a     = live_acc && (count == CNT_W'(NS));
  // Input acceptance wins over flush; the flush simply waits a cycle.
  assign trig_b     = !live_acc && i_flush && burst_running && !fifo_full;
  assign push       = trig_a || trig_b;
  assign pop        = !fifo_empty && i_axis_tready;

  // Slot layout: x/y/z zero-extended to 32-bit lanes, metadata in lane3 with last_bit at bit 0.
  always_comb begin
    slot_din = '0;
    slot_din[0  +: OW] = i_offset_pkt[0    +: OW];
    slot_din[32 +: OW] = i_offset_pkt[OW   +: OW];
    slot_din[64 +: OW] = i_offset_pkt[2*OW +: OW];
    slot_din[96 +: LANE3_W] = {i_offset_pkt[3*OW+ELEMENT_WIDTH +: PARTICLE_ID_WIDTH],
                               i_offset_pkt[3*OW +: ELEMENT_WIDTH],
                               i_gcid, i_lifetime, 1'b0};
  end

  for (genvar k = 0; k < NS; k++) begin : g_slot
    logic load, clr;
    // On a full-beat trigger the new packet restarts the beat in slot 0 and the rest are wiped.
    if (k == 0) begin : g_first
      assign load = live_acc && (trig_a || count == '0);
    end else begin : g_rest
      assign load = live_acc && !trig_a && (count == CNT_W'(k));
    end
    assign clr = trig_b || trig_a;

    ring_pos_slot #(.SUB_PACKET_WIDTH(SUB_PACKET_WIDTH)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .clr  (clr),
      .din  (slot_din),
      .q    (slot_q[k])
    );
  end

  always_comb begin
    beat_data = slot_q;
    beat_keep = '0;
    for (int k = 0; k < NS; k++) begin
      if (trig_b && count == CNT_W'(k+1)) beat_data[k][96] = 1'b1;
      if (trig_a || count > CNT_W'(k))    beat_keep[k] = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count                 <= '0;
      burst_running         <= 1'b0;
      o_debug_last_pos_sent <= 1'b0;
    end else begin
      o_debug_last_pos_sent <= trig_b;
      if (trig_a) begin
        count <= CNT_W'(1);
      end else if (live_acc) begin
        count         <= count + 1'b1;
        burst_running <= 1'b1;
      end else if (trig_b) begin
        count         <= '0;
        burst_running <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= beat_data;
      mem_keep[wr_ptr] <= beat_keep;
      mem_dest[wr_ptr] <= TDEST_WIDTH'(i_dest_id);
    end
  end

  // Head is masked while empty so stale entries never leak after reset or drain.
  assign o_axis_tvalid         = !fifo_empty;
  assign o_axis_tdata          = fifo_empty ? '0 : mem_data[rd_ptr];
  assign o_axis_tkeep          = fifo_empty ? '0 : mem_keep[rd_ptr];
  assign o_axis_tdest          = fifo_empty ? '0 : mem_dest[rd_ptr];
  assign o_axis_tlast          = 1'b1;
  assign o_fifo_count          = fifo_cnt;
  assign o_debug_burst_running = burst_running;

endmodule
